// File: rtl/alu_sequencer.sv
// Multi-cycle control stage feeding the combinational unit_A ALU from an internal register bank.
// Optional macro ALU_SEQ_OVF_EN adds the signed-overflow response flag rsp_ovf.
module alu_sequencer #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 8,
    parameter int REG_AW = 3,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ld,
    input  logic [1:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic [WIDTH-1:0]  cmd_imm,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [3:0]        alu_f,
    input  logic [WIDTH-1:0]  alu_s,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic              rsp_ovf
`endif
);

    // state   | meaning
    // IDLE    | waiting for a command, cmd_ready high
    // ISSUE   | ALU inputs held while the settle counter runs down
    // CAPTURE | sample S/c_out, write back to rd
    // RESP    | response presented until rsp_ready
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t            state;
    logic [WIDTH-1:0]  regs [NREGS];
    logic [REG_AW-1:0] rd_q;
    logic [3:0]        cnt;

    assign cmd_ready = (state == IDLE);

`ifdef ALU_SEQ_OVF_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    logic ovf_calc;

    always_comb begin
        ovf_calc = 1'b0;
        case (alu_f[1:0])
            2'b00:   ovf_calc = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_s[WIDTH-1] != alu_a[WIDTH-1]);
            2'b01:   ovf_calc = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_s[WIDTH-1] != alu_a[WIDTH-1]);
            2'b11:   ovf_calc = (alu_a == MAX_POS);
            default: ovf_calc = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            rd_q      <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_ld) begin
                            regs[cmd_rd] <= cmd_imm;
                            rsp_data     <= cmd_imm;
                            rsp_carry    <= 1'b0;
                            rsp_zero     <= (cmd_imm == '0);
`ifdef ALU_SEQ_OVF_EN
                            rsp_ovf      <= 1'b0;
`endif
                            rsp_valid    <= 1'b1;
                            state        <= RESP;
                        end else begin
                            // sources are read here, so rd may alias rs1/rs2 safely
                            alu_a <= regs[cmd_rs1];
                            alu_b <= regs[cmd_rs2];
                            alu_f <= {2'b01, cmd_op};
                            rd_q  <= cmd_rd;
                            cnt   <= CNT_INIT;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt == '0) state <= CAPTURE;
                    else           cnt   <= cnt - 4'd1;
                end
                CAPTURE: begin
                    regs[rd_q] <= alu_s;
                    rsp_data   <= alu_s;
                    rsp_carry  <= alu_cout;
                    rsp_zero   <= (alu_s == '0);
`ifdef ALU_SEQ_OVF_EN
                    rsp_ovf    <= ovf_calc;
`endif
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed test-plan steps then random commands against a register-bank model.
// Builds with or without ALU_SEQ_OVF_EN.
module tb_alu_sequencer;
    localparam int WIDTH  = 32;
    localparam int NREGS  = 8;
    localparam int REG_AW = 3;
    localparam int SETTLE = 2;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ld;
    logic [1:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_rs1;
    logic [REG_AW-1:0] cmd_rs2;
    logic [WIDTH-1:0]  cmd_imm;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [3:0]        alu_f;
    logic [WIDTH-1:0]  alu_s;
    logic              alu_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_carry;
    logic              rsp_zero;
`ifdef ALU_SEQ_OVF_EN
    logic              rsp_ovf;
`endif

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] mreg [NREGS];
    logic [WIDTH-1:0] last_a, last_b;
    logic [3:0]       last_f;

    alu_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS), .REG_AW(REG_AW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_s(alu_s), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`ifdef ALU_SEQ_OVF_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // unit_A stand-in: ripple-style carry chain result from a 33-bit add
    logic [WIDTH:0] ualu_t;
    always_comb begin
        ualu_t = '0;
        case (alu_f)
            4'b0100: ualu_t = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0101: ualu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            4'b0110: ualu_t = {1'b0, ~alu_a};
            4'b0111: ualu_t = {1'b0, alu_a} + 33'd1;
            default: ualu_t = '0;
        endcase
    end
    assign alu_s    = ualu_t[WIDTH-1:0];
    assign alu_cout = ualu_t[WIDTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference semantics in plain integer terms: carry = unsigned carry-out / no-borrow.
    task automatic ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] s, output logic c, output logic v);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                s = a + b;
                c = ((longint'(a) + longint'(b)) >= 64'sh1_0000_0000);
                r = sa + sb;
            end
            2'b01: begin
                s = a - b;
                c = (a >= b);
                r = sa - sb;
            end
            2'b10: begin
                s = ~a;
                c = 1'b0;
                r = 0;
            end
            default: begin
                s = a + 32'd1;
                c = (a == 32'hFFFF_FFFF);
                r = sa + 1;
            end
        endcase
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    task automatic do_cmd(input logic ld, input logic [1:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [31:0] imm, input int hold);
        logic [31:0] ea, eb, es;
        logic        ec, ev;
        logic [3:0]  ef;
        int          lat;
        ea = mreg[rs1];
        eb = mreg[rs2];
        ef = {2'b01, op};
        if (ld) begin
            es = imm; ec = 1'b0; ev = 1'b0;
        end else begin
            ref_alu(op, ea, eb, es, ec, ev);
        end
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_ld = ld; cmd_op = op; cmd_rd = rd;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            check("alu_f_issue", 64'(alu_f), 64'(ef));
            check("alu_a_issue", 64'(alu_a), 64'(ea));
            check("alu_b_issue", 64'(alu_b), 64'(eb));
            check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), ld ? 64'd1 : 64'(SETTLE + 2));
        if (ld) begin
            check("alu_f_kept", 64'(alu_f), 64'(last_f));
            check("alu_a_kept", 64'(alu_a), 64'(last_a));
        end else begin
            last_a = ea; last_b = eb; last_f = ef;
        end
        mreg[rd] = es;
        check("rsp_data", 64'(rsp_data), 64'(es));
        check("rsp_carry", 64'(rsp_carry), 64'(ec));
        check("rsp_zero", 64'(rsp_zero), 64'(es == 32'd0));
`ifdef ALU_SEQ_OVF_EN
        check("rsp_ovf", 64'(rsp_ovf), 64'(ev));
`endif
        for (int i = 0; i < hold; i++) begin
            if (hold >= 4 && i == 1) begin
                cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_rd = 3'd1; cmd_imm = 32'h0BAD_0BAD;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_data", 64'(rsp_data), 64'(es));
            check("bp_ready", 64'(cmd_ready), 64'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] rimm;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 2'b00;
        cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) mreg[i] = '0;
        last_a = '0; last_b = '0; last_f = '0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_alu_f", 64'(alu_f), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("ready_after_rst", 64'(cmd_ready), 64'd1);

        do_cmd(1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 32'd6, 0);
        do_cmd(1'b1, 2'b00, 3'd2, 3'd0, 3'd0, 32'd6, 0);
        do_cmd(1'b0, 2'b00, 3'd3, 3'd1, 3'd2, 32'd0, 0);
        do_cmd(1'b0, 2'b01, 3'd4, 3'd1, 3'd2, 32'd0, 0);
        do_cmd(1'b1, 2'b00, 3'd5, 3'd0, 3'd0, 32'd0, 0);
        do_cmd(1'b0, 2'b10, 3'd6, 3'd5, 3'd5, 32'd0, 0);
        do_cmd(1'b0, 2'b11, 3'd7, 3'd6, 3'd6, 32'd0, 0);
        do_cmd(1'b0, 2'b00, 3'd3, 3'd1, 3'd2, 32'd0, 5);
        do_cmd(1'b0, 2'b00, 3'd3, 3'd1, 3'd2, 32'd0, 0);
        do_cmd(1'b0, 2'b00, 3'd1, 3'd1, 3'd1, 32'd0, 0);
        do_cmd(1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 32'h7FFF_FFFF, 0);
        do_cmd(1'b0, 2'b11, 3'd2, 3'd0, 3'd0, 32'd0, 0);

        // abort an ALU op from inside ISSUE
        cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = 2'b00;
        cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_alu_a", 64'(alu_a), 64'd0);
        check("abort_alu_f", 64'(alu_f), 64'd0);
        check("abort_valid", 64'(rsp_valid), 64'd0);
        check("abort_data", 64'(rsp_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) mreg[i] = '0;
        last_a = '0; last_b = '0; last_f = '0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("abort_no_rsp", 64'(seen), 64'd0);
        do_cmd(1'b0, 2'b00, 3'd3, 3'd1, 3'd2, 32'd0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(3))
                0:       rimm = 32'd0;
                1:       rimm = 32'h7FFF_FFFF;
                2:       rimm = 32'hFFFF_FFFF;
                default: rimm = $urandom;
            endcase
            do_cmd(($urandom_range(2) == 0), 2'($urandom_range(3)), 3'($urandom_range(7)),
                   3'($urandom_range(7)), 3'($urandom_range(7)), rimm, int'($urandom_range(2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
